// File: rtl/stream_zero_pad.sv
// Streams an IMG_H x IMG_W frame out as an OH x OW frame with a PAD-pixel border.
// The border is either zeros or a constant latched at frame start; one output register, 1-cycle latency.
module stream_zero_pad #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 1,
    parameter int IMG_H    = 5,
    parameter int IMG_W    = 5,
    parameter int PAD      = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         start,
    input  logic                         pad_mode,
    input  logic [DATA_W-1:0]            pad_val,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);
    localparam int BW = CHANNELS * DATA_W;
    localparam int OH = IMG_H + 2 * PAD;
    localparam int OW = IMG_W + 2 * PAD;
    localparam int RW = $clog2(OH + 1);
    localparam int CW = $clog2(OW + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic              mode_q;
    logic [DATA_W-1:0] pad_q;
    logic              interior, at_end, row_end, slot_free, produce, done_nxt;
    logic [BW-1:0]     pad_word;

    assign interior  = (int'(row) >= PAD) && (int'(row) < PAD + IMG_H) &&
                       (int'(col) >= PAD) && (int'(col) < PAD + IMG_W);
    assign row_end   = (col == CW'(OW - 1));
    assign at_end    = row_end && (row == RW'(OH - 1));
    assign slot_free = !out_valid || out_ready;
    assign produce   = (state == RUN) && en && slot_free && (!interior || in_valid);
    assign pad_word  = mode_q ? {CHANNELS{pad_q}} : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (produce && at_end) state_nxt = DRAIN;
            DRAIN:   if (slot_free) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        in_ready = (state == RUN) && en && interior && slot_free;
        done_nxt = (state == DRAIN) && slot_free;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row       <= '0;
            col       <= '0;
            mode_q    <= 1'b0;
            pad_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_nxt;
            // Pad settings are captured only when a frame is accepted.
            if (state == IDLE && start) begin
                mode_q <= pad_mode;
                pad_q  <= pad_val;
                row    <= '0;
                col    <= '0;
            end
            if (produce) begin
                out_data  <= interior ? in_data : pad_word;
                out_valid <= 1'b1;
                out_last  <= at_end;
                if (row_end) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_zero_pad.sv
// Scoreboard bench for stream_zero_pad: three instances (2x2 pad 1, 5x5 pad 1 two-channel, 5x5 pad 0)
// share stimulus; only the selected one is started, and a negedge monitor checks its output stream.
module tb_stream_zero_pad;
    logic        clk = 1'b0;
    logic        reset, en, start, pad_mode, in_valid, out_ready;
    logic [31:0] pad_val, in_data;

    logic [31:0] a_od, b_od, c_od;
    logic        a_ov, b_ov, c_ov, a_ol, b_ol, c_ol, a_ir, b_ir, c_ir;
    logic        a_busy, b_busy, c_busy, a_done, b_done, c_done;

    int          sel;
    logic [31:0] md;
    logic        mv, ml, mir, mbusy, mdone;

    typedef struct packed { logic l; logic [31:0] d; } exp_t;
    exp_t exp_q[$];

    int n_chk = 0, n_fail = 0, n_out = 0, cycle = 0, last_cyc = -100, done_cyc = -100;

    always #5 clk = ~clk;

    stream_zero_pad #(.DATA_W(32), .CHANNELS(1), .IMG_H(2), .IMG_W(2), .PAD(1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .start(start && sel == 0), .pad_mode(pad_mode),
        .pad_val(pad_val), .in_data(in_data), .in_valid(in_valid), .in_ready(a_ir),
        .out_data(a_od), .out_valid(a_ov), .out_ready(out_ready), .out_last(a_ol),
        .busy(a_busy), .done(a_done));

    stream_zero_pad #(.DATA_W(16), .CHANNELS(2), .IMG_H(5), .IMG_W(5), .PAD(1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .start(start && sel == 1), .pad_mode(pad_mode),
        .pad_val(pad_val[15:0]), .in_data(in_data), .in_valid(in_valid), .in_ready(b_ir),
        .out_data(b_od), .out_valid(b_ov), .out_ready(out_ready), .out_last(b_ol),
        .busy(b_busy), .done(b_done));

    stream_zero_pad #(.DATA_W(32), .CHANNELS(1), .IMG_H(5), .IMG_W(5), .PAD(0)) dut_c (
        .clk(clk), .reset(reset), .en(en), .start(start && sel == 2), .pad_mode(pad_mode),
        .pad_val(pad_val), .in_data(in_data), .in_valid(in_valid), .in_ready(c_ir),
        .out_data(c_od), .out_valid(c_ov), .out_ready(out_ready), .out_last(c_ol),
        .busy(c_busy), .done(c_done));

    always_comb begin
        md = a_od; mv = a_ov; ml = a_ol; mir = a_ir; mbusy = a_busy; mdone = a_done;
        if (sel == 1) begin
            md = b_od; mv = b_ov; ml = b_ol; mir = b_ir; mbusy = b_busy; mdone = b_done;
        end else if (sel == 2) begin
            md = c_od; mv = c_ov; ml = c_ol; mir = c_ir; mbusy = c_busy; mdone = c_done;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cycle);
        end
    endtask

    // Monitor: a transfer is seen at the negedge before the edge that completes it.
    initial begin
        exp_t        e;
        logic        prev_stall = 1'b0;
        logic [32:0] prev = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("stall_hold", {ml, md}, prev);
                if (mv && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", {ml, md}, 33'h1_DEADBEEF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pixel", {ml, md}, {e.l, e.d});
                    end
                    if (ml) last_cyc = cycle;
                end
                if (mdone) done_cyc = cycle;
                prev_stall = mv && !out_ready;
                prev = {ml, md};
            end
        end
    end

    task automatic run_frame(input int s, input int h, input int w, input int p, input bit mode,
                             input logic [31:0] pv, input int base, input bit toggle_rdy,
                             input bit rand_vld, input int gap_at, input int stop_after);
        int          oh = h + 2 * p, ow = w + 2 * p, k = 0, idx = 0, cyc = 0, out0;
        logic [31:0] pw, pend_val = '0;
        bit          got_done = 0, pend = 0;
        exp_t        e;
        pw = !mode ? 32'h0 : (s == 1) ? {pv[15:0], pv[15:0]} : pv;
        for (int r = 0; r < oh; r++)
            for (int c = 0; c < ow; c++) begin
                if (r >= p && r < p + h && c >= p && c < p + w) begin
                    e.d = base + k; k++;
                end else e.d = pw;
                e.l = (r == oh - 1) && (c == ow - 1);
                exp_q.push_back(e);
            end
        sel  = s;
        out0 = n_out;
        while (!got_done && cyc < 3000) begin
            @(posedge clk); #1;
            start     = (cyc == 0) || (gap_at >= 0 && (cyc == gap_at + 2 || cyc == gap_at + 7));
            pad_mode  = (cyc == 0) ? mode : ~mode;
            pad_val   = (cyc == 0) ? pv : ~pv;
            en        = !(gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 5);
            out_ready = toggle_rdy ? (cyc % 2 == 0) : 1'b1;
            in_valid  = (idx < h * w) && (!rand_vld || $urandom_range(0, 2) != 0);
            in_data   = base + idx;
            @(negedge clk); #1;
            if (pend) begin
                chk("lat1_valid", mv, 1'b1);
                chk("lat1_data", md, pend_val);
                pend = 0;
            end
            if (gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 5) begin
                chk("en0_in_ready", mir, 1'b0);
                chk("en0_busy", mbusy, 1'b1);
                if (cyc > gap_at) chk("en0_no_out", mv, 1'b0);
            end
            if (in_valid && mir) begin
                idx++;
                if (p == 0) begin pend = 1; pend_val = in_data; end
            end
            if (stop_after > 0 && n_out - out0 >= stop_after) return;
            if (mdone) got_done = 1;
            cyc++;
        end
        chk("frame_done_seen", got_done, 1'b1);
        chk("done_after_last", done_cyc - last_cyc, 1);
        chk("out_count", n_out - out0, oh * ow);
        chk("inputs_used", idx, h * w);
        chk("queue_empty", exp_q.size(), 0);
        @(negedge clk); #1;
        chk("done_one_cycle", mdone, 1'b0);
        chk("idle_busy", mbusy, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk({tag, "_valid"}, mv, 1'b0);
            chk({tag, "_data"}, md, 32'h0);
            chk({tag, "_last"}, ml, 1'b0);
            chk({tag, "_busy"}, mbusy, 1'b0);
            chk({tag, "_done"}, mdone, 1'b0);
            chk({tag, "_in_ready"}, mir, 1'b0);
        end
    endtask

    initial begin
        reset = 1; en = 0; start = 0; pad_mode = 0; pad_val = '0;
        in_valid = 0; in_data = '0; out_ready = 1; sel = 0;
        repeat (3) @(posedge clk);
        #1 chk_reset_state("rst");
        @(negedge clk); reset = 0;

        run_frame(0, 2, 2, 1, 0, 32'h0,        1,   0, 0, -1, 0);
        run_frame(0, 2, 2, 1, 1, 32'hFFFFFFFF, 1,   0, 0, -1, 0);
        run_frame(1, 5, 5, 1, 1, 32'h0000A5C3, 100, 1, 0, -1, 0);
        run_frame(2, 5, 5, 0, 0, 32'h0,        0,   0, 1, -1, 0);

        // Abandon a frame after its 10th output, then restart from (0,0).
        run_frame(1, 5, 5, 1, 0, 32'h0, 200, 0, 0, -1, 10);
        reset = 1;
        #1 chk_reset_state("midrst");
        repeat (2) @(posedge clk);
        #1 chk_reset_state("midrst_hold");
        exp_q.delete();
        @(negedge clk); reset = 0;
        run_frame(1, 5, 5, 1, 0, 32'h0,        300, 0, 0, -1, 0);
        run_frame(1, 5, 5, 1, 1, 32'h00001234, 400, 0, 0, 20, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/stream_zero_pad.md
STREAM_ZERO_PAD -- requirements
Module: stream_zero_pad

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bits per channel element.
REQ-002 SHALL have parameter CHANNELS, default 1, elements per pixel; bus width BW = CHANNELS*DATA_W.
REQ-003 SHALL have parameters IMG_H, IMG_W, default 5, 5, input frame rows/cols (each >= 1).
REQ-004 SHALL have parameter PAD, default 1, pad border width in pixels (>= 0); OH = IMG_H+2*PAD, OW = IMG_W+2*PAD.
REQ-005 SHALL have ports: clk  in  1  single clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-006 SHALL have ports: en  in  1  global advance enable; start  in  1  frame start pulse; pad_mode  in  1  0=zero, 1=constant; pad_val  in  DATA_W  constant pad element.
REQ-007 SHALL have ports: in_data  in  BW  input pixel; in_valid  in  1; in_ready  out  1.
REQ-008 SHALL have ports: out_data  out  BW  padded pixel; out_valid  out  1; out_ready  in  1; out_last  out  1  last pixel of frame.
REQ-009 SHALL have ports: busy  out  1  state != IDLE; done  out  1  one-cycle frame-complete pulse.

Function
REQ-010 SHALL emit OH*OW pixels per frame in raster order (row-major, row 0 col 0 first), consuming exactly IMG_H*IMG_W inputs in raster order.
REQ-011 SHALL treat position (r,c) as interior iff PAD <= r < PAD+IMG_H and PAD <= c < PAD+IMG_W; all other positions are pad.
REQ-012 SHALL output pad word = all zeros when latched mode = 0, else pad_val replicated into every channel.
REQ-013 SHALL latch pad_mode and pad_val when start is accepted; changes mid-frame have no effect.
REQ-014 SHALL implement FSM IDLE -> RUN on start=1; RUN -> DRAIN on producing last pixel; DRAIN -> IDLE when output register empties or out_valid&out_ready.
REQ-015 SHALL ignore start while in RUN or DRAIN.
REQ-016 SHALL define slot_free = !out_valid | out_ready and produce = (state==RUN) & en & slot_free & (pad position | in_valid).
REQ-017 SHALL drive in_ready = (state==RUN) & en & interior position & slot_free, combinationally; an input is consumed iff in_valid & in_ready.
REQ-018 SHALL on produce register out_data (pad word or in_data), set out_valid=1, set out_last=1 iff position is (OH-1,OW-1), and advance col, wrapping to 0 with row+1 at OW-1.
REQ-019 SHALL on !produce & out_ready clear out_valid; out_data/out_last SHALL hold while out_valid & !out_ready.
REQ-020 SHALL have 1-cycle latency: input accepted at edge N appears on out_data after edge N.
REQ-021 SHALL, with start sampled at edge N, produce the first pixel at edge N+1 if en=1 and (PAD>0 or in_valid=1).
REQ-022 SHALL sustain one pixel per cycle with en=1, out_ready=1, in_valid=1.
REQ-023 SHALL, when en=0, produce nothing and hold in_ready=0; a pending out_valid still completes on out_ready.
REQ-024 SHALL pulse done for exactly one cycle on the DRAIN -> IDLE transition; in_ready=0 in IDLE and DRAIN.
REQ-025 SHALL, with PAD=0, behave as registered passthrough of IMG_H*IMG_W pixels.

Reset
REQ-026 SHALL on reset=1 asynchronously force state=IDLE, row=col=0, out_valid=0, out_last=0, out_data=0, done=0, busy=0, latched mode/pad_val=0.
REQ-027 SHALL, on reset mid-frame, abandon the frame; next frame starts fresh after a new start.

Verification
REQ-028 IMG 2x2, PAD=1, inputs 1,2,3,4, out_ready=1 -> 16 outputs 0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0; out_last on 16th; done one cycle later.
REQ-029 Same frame, pad_mode=1, pad_val=0xFFFFFFFF -> pad positions 0xFFFFFFFF, interior 1..4, 16 outputs.
REQ-030 5x5, PAD=1, out_ready toggled 1010... -> 49 outputs, no pixel lost or duplicated, out_data stable while stalled.
REQ-031 PAD=0, 5x5, inputs 0..24, in_valid random -> outputs 0..24 in order, each 1 cycle after acceptance.
REQ-032 Reset asserted after 10th output, then start -> all outputs 0 during reset, new frame restarts at (0,0), 49 outputs.
REQ-033 en=0 for 5 cycles mid-frame and start pulsed during RUN -> no production, in_ready=0, frame unaffected, 49 outputs total.
